// File: rtl/net_fc3_pkg.sv
// Shared types, dimensions, weight tables and arithmetic helpers for the
// three-layer fully-connected inference pipeline.
package net_fc3_pkg;

    localparam int unsigned T  = 16;   // data / weight width
    localparam int unsigned N  = 4;    // input vector length
    localparam int unsigned M1 = 8;    // layer-1 outputs
    localparam int unsigned M2 = 12;   // layer-2 outputs
    localparam int unsigned M3 = 16;   // layer-3 (final) outputs
    localparam int unsigned R  = 1;    // 1 = ReLU after every layer
    localparam int unsigned P  = 20;   // multiplier budget across all layers

    // Rows evaluated in parallel per layer (one multiplier per row)
    localparam int unsigned PAR1 = 2;
    localparam int unsigned PAR2 = 4;
    localparam int unsigned PAR3 = 8;

    typedef logic signed [T-1:0]   data_t;
    typedef logic signed [2*T-1:0] prod_t;
    typedef logic signed [2*T+3:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } layer_state_t;

    localparam acc_t ACC_MAX = acc_t'(32'sd32767);
    localparam acc_t ACC_MIN = acc_t'(-32'sd32768);

    // Flat row-major weight tables, sized for the largest matrix (M3 x M2)
    localparam int unsigned WMAX = M3 * M2;
    typedef logic [WMAX*T-1:0] wtab_t;

    // Deterministic small-valued weight pattern in [-3, 3]
    function automatic data_t wgen(int unsigned lid, int unsigned i, int unsigned k);
        int unsigned h;
        h = (i * 5 + k * 3 + lid * 7 + i * k) % 7;
        return data_t'(int'(h) - 3);
    endfunction

    function automatic wtab_t build_w(int unsigned lid, int unsigned rows, int unsigned cols);
        wtab_t v;
        v = '0;
        for (int unsigned i = 0; i < rows; i++) begin
            for (int unsigned k = 0; k < cols; k++) begin
                v[(i * cols + k) * T +: T] = wgen(lid, i, k);
            end
        end
        return v;
    endfunction

    localparam wtab_t W1 = build_w(1, M1, N);
    localparam wtab_t W2 = build_w(2, M2, M1);
    localparam wtab_t W3 = build_w(3, M3, M2);

    // Weight lookup W<lid>[row][col]
    function automatic data_t weight(int unsigned lid, int unsigned row, int unsigned col);
        data_t w;
        w = '0;
        case (lid)
            1:       w = W1[(row * N  + col) * T +: T];
            2:       w = W2[(row * M1 + col) * T +: T];
            3:       w = W3[(row * M2 + col) * T +: T];
            default: w = '0;
        endcase
        return w;
    endfunction

    // Full-precision signed product, widened to accumulator width
    function automatic acc_t mul(data_t a, data_t b);
        prod_t ae;
        prod_t be;
        ae = prod_t'(a);
        be = prod_t'(b);
        return acc_t'(ae * be);
    endfunction

    // Saturate to the data range, then optionally clamp negatives to zero
    function automatic data_t activate(acc_t a, logic relu);
        acc_t s;
        if (a > ACC_MAX) begin
            s = ACC_MAX;
        end else if (a < ACC_MIN) begin
            s = ACC_MIN;
        end else begin
            s = a;
        end
        if (relu && s[2*T+3]) begin
            s = '0;
        end
        return s[T-1:0];
    endfunction

endpackage

// File: rtl/net_fc3_4_8_12_fc_layer.sv
// One fully-connected layer: captures a whole input vector, evaluates PAR
// rows per cycle group while stepping one column per cycle, then holds the
// result vector until the downstream stage takes it.
module fc_layer
    import net_fc3_pkg::*;
#(
    parameter int unsigned FANIN  = 4,
    parameter int unsigned FANOUT = 8,
    parameter int unsigned PAR    = 2,
    parameter int unsigned RELU   = 1,
    parameter int unsigned LID    = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_vec [FANIN],
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_vec [FANOUT]
);

    localparam int unsigned GROUPS = FANOUT / PAR;
    localparam int unsigned CW     = (FANIN  > 1) ? $clog2(FANIN)  : 1;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned RW     = (FANOUT > 1) ? $clog2(FANOUT) : 1;

    layer_state_t  state;
    logic [CW-1:0] col;
    logic [GW-1:0] grp;
    logic          last_col;
    logic          last_grp;

    data_t xbuf [FANIN];
    data_t res  [FANOUT];
    data_t rom  [FANOUT][FANIN];
    acc_t  acc  [PAR];
    acc_t  sum  [PAR];

    assign last_col = (col == CW'(FANIN - 1));
    assign last_grp = (grp == GW'(GROUPS - 1));

    // Constant weight ROM for this layer
    for (genvar r = 0; r < FANOUT; r++) begin : g_rom_row
        for (genvar c = 0; c < FANIN; c++) begin : g_rom_col
            assign rom[r][c] = weight(LID, r, c);
        end
    end

    // Multiply-accumulate for the PAR rows of the current group; column 0
    // restarts the accumulation so no separate clear cycle is needed
    always_comb begin
        for (int unsigned p = 0; p < PAR; p++) begin
            sum[p] = ((col == '0) ? '0 : acc[p])
                   + mul(rom[RW'(grp * PAR + p)][col], xbuf[col]);
        end
    end

    // Layer control FSM: IDLE waits for a vector, COMPUTE walks groups and
    // columns, DONE holds results until the next stage accepts them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            grp       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_COMPUTE;
                        in_ready <= 1'b0;
                        col      <= '0;
                        grp      <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (last_col) begin
                        col <= '0;
                        if (last_grp) begin
                            grp       <= '0;
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            grp <= grp + GW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture the input vector, accumulate, and write finished rows
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            for (int unsigned k = 0; k < FANIN; k++) begin
                xbuf[k] <= in_vec[k];
            end
        end
        if (state == ST_COMPUTE) begin
            for (int unsigned p = 0; p < PAR; p++) begin
                if (last_col) begin
                    res[RW'(grp * PAR + p)] <= activate(sum[p], RELU != 0);
                end else begin
                    acc[p] <= sum[p];
                end
            end
        end
    end

    assign out_vec = res;

endmodule

// File: rtl/net_fc3_4_8_12.sv
// Three-layer fully-connected pipeline (4 -> 8 -> 12 -> 16) between two
// element-serial valid/ready streams. The top gathers input elements into
// the first layer's input vector, chains the layers, and serializes the
// final vector onto the output stream.
module net_fc3_4_8_12
    import net_fc3_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [T-1:0] input_data,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [T-1:0] output_data
);

    localparam int unsigned NW = $clog2(N);
    localparam int unsigned OW = $clog2(M3);

    // Input gather (layer-1 input buffer)
    data_t         in_buf [N];
    logic [NW-1:0] in_cnt;
    logic          in_full;
    logic          alive;
    logic          in_fire;

    // Inter-layer handshakes and vectors
    logic  l1_in_ready, l1_valid, l2_in_ready, l2_valid, l3_in_ready, l3_valid;
    logic  l3_out_ready;
    data_t l1_vec [M1];
    data_t l2_vec [M2];
    data_t l3_vec [M3];

    // Output serializer
    data_t         out_buf [M3];
    logic [OW-1:0] out_cnt;
    logic          out_full;
    logic          out_fire;
    logic          out_last;
    logic          out_load;

    assign input_ready = alive & ~in_full;
    assign in_fire     = input_valid & input_ready;

    assign out_fire     = out_full & output_ready;
    assign out_last     = (out_cnt == OW'(M3 - 1));
    // The next vector may load in the same cycle the last element leaves
    assign l3_out_ready = ~out_full | (out_fire & out_last);
    assign out_load     = l3_valid & l3_out_ready;

    assign output_valid = out_full;
    assign output_data  = out_buf[out_cnt];

    // Input gather control: count elements, flag a full vector, release it
    // once layer 1 has captured it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive   <= 1'b0;
            in_cnt  <= '0;
            in_full <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (in_full && l1_in_ready) begin
                in_full <= 1'b0;
            end
            if (in_fire) begin
                if (in_cnt == NW'(N - 1)) begin
                    in_cnt  <= '0;
                    in_full <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + NW'(1);
                end
            end
        end
    end

    // Input gather storage
    always_ff @(posedge clk) begin
        if (in_fire) begin
            in_buf[in_cnt] <= input_data;
        end
    end

    fc_layer #(
        .FANIN  (N),
        .FANOUT (M1),
        .PAR    (PAR1),
        .RELU   (R),
        .LID    (1)
    ) u_l1 (
        .clk       (clk),
        .rst       (reset),
        .in_valid  (in_full),
        .in_ready  (l1_in_ready),
        .in_vec    (in_buf),
        .out_valid (l1_valid),
        .out_ready (l2_in_ready),
        .out_vec   (l1_vec)
    );

    fc_layer #(
        .FANIN  (M1),
        .FANOUT (M2),
        .PAR    (PAR2),
        .RELU   (R),
        .LID    (2)
    ) u_l2 (
        .clk       (clk),
        .rst       (reset),
        .in_valid  (l1_valid),
        .in_ready  (l2_in_ready),
        .in_vec    (l1_vec),
        .out_valid (l2_valid),
        .out_ready (l3_in_ready),
        .out_vec   (l2_vec)
    );

    fc_layer #(
        .FANIN  (M2),
        .FANOUT (M3),
        .PAR    (PAR3),
        .RELU   (R),
        .LID    (3)
    ) u_l3 (
        .clk       (clk),
        .rst       (reset),
        .in_valid  (l2_valid),
        .in_ready  (l3_in_ready),
        .in_vec    (l2_vec),
        .out_valid (l3_valid),
        .out_ready (l3_out_ready),
        .out_vec   (l3_vec)
    );

    // Output serializer control: step through y[0]..y[M3-1], reload on demand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_full <= 1'b0;
            out_cnt  <= '0;
        end else begin
            if (out_fire) begin
                if (out_last) begin
                    out_cnt  <= '0;
                    out_full <= 1'b0;
                end else begin
                    out_cnt <= out_cnt + OW'(1);
                end
            end
            if (out_load) begin
                out_full <= 1'b1;
            end
        end
    end

    // Output serializer storage
    always_ff @(posedge clk) begin
        if (out_load) begin
            for (int unsigned i = 0; i < M3; i++) begin
                out_buf[i] <= l3_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_net_fc3_4_8_12.sv
// Randomized self-checking bench for net_fc3_4_8_12 with a queue-based
// matrix-arithmetic reference model.
module tb_net_fc3_4_8_12;
    import net_fc3_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         input_valid;
    logic         input_ready;
    logic [T-1:0] input_data;
    logic         output_valid;
    logic         output_ready;
    logic [T-1:0] output_data;

    always #5 clk = ~clk;

    net_fc3_4_8_12 dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          in_q[$];
    int          exp_q[$];
    int unsigned in_prob  = 100;
    int unsigned out_prob = 100;
    bit          stall    = 1'b0;
    int unsigned cyc      = 0;
    int          out_count = 0;
    int          in_sent   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int act(longint a);
        longint s;
        s = a;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (R == 1 && s < 0) s = 0;
        return int'(s);
    endfunction

    // Reference: y = act(W3 * act(W2 * act(W1 * x)))
    task automatic push_vec(input int x [N]);
        int     h1 [M1];
        int     h2 [M2];
        longint s;
        for (int unsigned i = 0; i < M1; i++) begin
            s = 0;
            for (int unsigned k = 0; k < N; k++)
                s += longint'(weight(1, i, k)) * longint'(x[k]);
            h1[i] = act(s);
        end
        for (int unsigned i = 0; i < M2; i++) begin
            s = 0;
            for (int unsigned k = 0; k < M1; k++)
                s += longint'(weight(2, i, k)) * longint'(h1[k]);
            h2[i] = act(s);
        end
        for (int unsigned i = 0; i < M3; i++) begin
            s = 0;
            for (int unsigned k = 0; k < M2; k++)
                s += longint'(weight(3, i, k)) * longint'(h2[k]);
            exp_q.push_back(act(s));
        end
        for (int unsigned k = 0; k < N; k++) in_q.push_back(x[k]);
    endtask

    function automatic int rnd_elem();
        int unsigned cls;
        cls = $urandom_range(2);
        case (cls)
            0:       return int'($urandom_range(32)) - 16;
            1:       return int'($urandom_range(1024)) - 512;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    task automatic push_random(int unsigned count);
        int x [N];
        for (int unsigned v = 0; v < count; v++) begin
            for (int unsigned k = 0; k < N; k++) x[k] = rnd_elem();
            push_vec(x);
        end
    endtask

    task automatic wait_drain(int unsigned budget, string tag);
        int unsigned n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Caller enters just after a rising edge; reset is asserted immediately
    task automatic do_reset();
        reset = 1'b1;
        in_q.delete();
        exp_q.delete();
        #1;
        check_eq("rst_out_valid", output_valid, 0);
        check_eq("rst_in_ready", input_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #2;
        check_eq("post_rst_in_ready", input_ready, 1);
    endtask

    // Input driver
    initial begin
        bit fire;
        input_valid = 1'b0;
        input_data  = '0;
        forever begin
            @(negedge clk);
            fire = input_valid && input_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                void'(in_q.pop_front());
                in_sent++;
            end
            if (in_q.size() != 0 && $urandom_range(99) < in_prob) begin
                input_valid = 1'b1;
                input_data  = T'(in_q[0]);
            end else begin
                input_valid = 1'b0;
            end
        end
    end

    // Output ready driver
    initial begin
        output_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            output_ready = !stall && ($urandom_range(99) < out_prob);
        end
    end

    // Output monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && output_valid && output_ready) begin
                check_eq("out_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check_eq("out_data", int'($signed(output_data)), exp_q.pop_front());
                out_count++;
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL global_timeout: cycles %0d limit %0d", cyc, 95000);
        $fatal(1);
    end

    initial begin
        int unsigned start;
        int unsigned n;
        int          base;
        int          held;

        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_eq("reset_out_valid", output_valid, 0);
        check_eq("reset_in_ready", input_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #2;
        check_eq("first_cycle_in_ready", input_ready, 1);
        check_eq("first_cycle_out_valid", output_valid, 0);

        // Directed vectors: zeros, saturating extremes, mixed signs
        in_prob  = 100;
        out_prob = 100;
        push_vec('{0, 0, 0, 0});
        push_vec('{32767, 32767, 32767, 32767});
        push_vec('{-32768, -32768, -32768, -32768});
        push_vec('{5, -3, 7, 32767});
        push_vec('{1, 1, 1, 1});
        wait_drain(3000, "drain_directed");

        // Full-rate throughput
        start = cyc;
        push_random(100);
        wait_drain(8000, "drain_fullrate");
        check_eq("throughput", int'((cyc - start) <= 100 * 32 + 100), 1);

        // Random valid/ready at 50%
        in_prob  = 50;
        out_prob = 50;
        push_random(600);
        wait_drain(40000, "drain_random");

        // Output stall mid-vector
        in_prob  = 100;
        out_prob = 100;
        push_random(20);
        n = 0;
        while (!(out_count % 16 == 5 && output_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("stall_setup", out_count % 16, 5);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        held = int'(output_data);
        check_eq("stall_valid", output_valid, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i % 20 == 0) begin
                check_eq("stall_data_stable", int'(output_data), held);
                check_eq("stall_valid_held", output_valid, 1);
            end
        end
        check_eq("stall_backpressure", input_ready, 0);
        stall = 1'b0;
        wait_drain(5000, "drain_after_stall");

        // Reset after two elements of a vector were accepted
        base = in_sent;
        push_vec('{100, 200, 300, 400});
        n = 0;
        while (in_sent < base + 2 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("rst_mid_input_setup", in_sent - base, 2);
        do_reset();
        base = out_count;
        push_vec('{1, 1, 1, 1});
        wait_drain(2000, "drain_after_rst1");
        repeat (60) @(posedge clk);
        check_eq("rst1_exact16", out_count - base, 16);

        // Reset in the middle of an output vector
        out_prob = 50;
        push_random(3);
        n = 0;
        while (!(out_count % 16 == 7) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("rst_mid_output_setup", (out_count - base) % 16, 7);
        do_reset();
        base = out_count;
        push_vec('{1, 1, 1, 1});
        wait_drain(3000, "drain_after_rst2");
        repeat (60) @(posedge clk);
        check_eq("rst2_exact16", out_count - base, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/net_fc3_4_8_12.md
Name: net_fc3_4_8_12

Overview:
- Three-layer fully-connected inference pipeline with parameter tuple N=4, M1=8, M2=12, M3=16, T=16, R=1, P=20.
- Accepts a stream of 4-element signed input vectors and emits one 16-element signed output vector per input vector.
- Layer chain: 4->8 -> 8->12 -> 12->16, each layer computing y = ReLU(sat(W·x)).
- Sits between two valid/ready streaming interfaces.

Parameters:
- N, 4, input vector length
- M1, 8, layer-1 output length
- M2, 12, layer-2 output length
- M3, 16, layer-3 (final) output length
- T, 16, data/weight width, signed two's complement
- R, 1, 1 = apply ReLU after every layer; 0 = no ReLU
- P, 20, upper bound on total multipliers across all layers

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- input_valid  in  1  input_data holds a valid element
- input_ready  out  1  block can accept an element this cycle
- input_data  in  T  signed input element; vector order x[0]..x[N-1]
- output_valid  out  1  output_data holds a valid element
- output_ready  in  1  downstream accepts this cycle
- output_data  out  T  signed output element; order y[0]..y[M3-1]

Interface (already decided): one clock (clk); reset is asynchronous and active-high (reset).

Behaviour:
- Transfers:
  - Input transfer occurs on a rising edge with input_valid && input_ready.
  - Output transfer occurs on a rising edge with output_valid && output_ready.
  - Element counts are not tied to cycles; either side may stall arbitrarily.
- Output hold: while output_valid=1 and output_ready=0, output_data stays stable and output_valid stays 1.
- Reset values:
  - input_ready=0 during reset, 1 on the first cycle after reset.
  - output_valid=0; all element/vector counters and buffer-full flags cleared.
  - Weight ROMs are unaffected by reset.
  - A reset mid-vector discards all partial data; the next accepted element is x[0] of a new vector.
- Weights: W1 (M1xN), W2 (M2xM1), W3 (M3xM2), signed T-bit, row-major constant tables from the shared package. No bias.
- Arithmetic per output element: acc = Σ W[i][k]·x[k].
  - Each product is full 2T bits; acc is 2T+4 bits, so it cannot overflow.
  - Result is saturated to [-32768, 32767]; if R=1, negative results become 0.
  - No fractional shift.
- Layer stage:
  - Each layer has an input vector buffer (length = its fan-in) filled by upstream; it starts computing once the buffer is full and the output buffer is free.
  - Multipliers per layer: L1=2, L2=4, L3=8 (total 14 ≤ P).
  - Compute cycles per vector: 16, 24, 24.
  - Each layer evaluates Pk rows in parallel, accumulating one column per cycle.
- Layer-k FSM states:
  - IDLE (filling input buffer)
  - COMPUTE (column counter 0..fan-in-1, row-group counter)
  - DONE (results held until the next layer's/output buffer has consumed them)
- Concurrency:
  - Input buffer of L1 is released (input_ready reasserted) as soon as COMPUTE has captured it, so L1 can accept the next vector while the downstream layers work.
  - Vectors never reorder or interleave.
- Output buffer: the 16 final values are presented sequentially y[0]..y[15]. The next vector's outputs follow immediately if ready.
- Boundaries:
  - Simultaneous final input element and final output element transfers are both honoured.
  - A stall on output back-pressures all layers, eventually deasserting input_ready. No data is lost or duplicated.
- Throughput target: ≥1 vector per 32 cycles when both sides are always ready.

Decomposition:
- Package net_fc3_pkg: T, N, M1..M3, R, per-layer multiplier counts, typedef data_t (signed [T-1:0]), acc_t (signed [2T+3:0]), weight arrays W1/W2/W3, saturate/relu function.
- One sub-module fc_layer #(FANIN, FANOUT, PAR, R, layer id) instantiated three times, with valid/ready between layers. The top holds only the wiring and the output serializer.

Test Plan:
- All-zero input vector [0,0,0,0] -> 16 outputs all 0x0000.
- Bench package with identity-embedded weights (W[i][i]=1, else 0), input [5,-3,7,32767] -> y = [5,0,7,32767, then 12 zeros]; the -3 becomes 0 via ReLU.
- Saturation: all weights = 32767, input [32767,32767,32767,32767] -> every output 0x7FFF. Inputs all -32768 with all weights = 32767 -> every output 0x0000 (layer 1 saturates to -32768, ReLU clamps).
- Random valid/ready (50% each), 2500 random vectors with production weights -> 40000 outputs match golden model, 0 errors, ordering preserved.
- output_ready held 0 for 200 cycles mid-vector -> output_data stable, input_ready drops to 0, no element lost after release.
- Reset asserted mid-vector (after 2 elements accepted, and again mid-output) -> output_valid=0 immediately. After release, fresh vector [1,1,1,1] yields exactly 16 correct outputs.
